// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: DEPTH valid/ready stages with bubble collapse and per-stage flush.
// Optional PIPE_CHAIN_STATS_EN adds saturating stall_count and flush_count outputs.
module pipe_stage_chain #(
  parameter int                WIDTH      = 32,
  parameter int                DEPTH      = 4,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [DEPTH-1:0]             flush,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [31:0]                  stall_count,
  output logic [31:0]                  flush_count
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] x);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(x[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] adv;

  assign ev = vld_p & ~flush;

  // A stage advances when it is empty (or flushed) or the stage ahead advances.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~ev[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) adv[i] = ~ev[i] | adv[i+1];
  end

  assign in_ready    = adv[0];
  assign out_valid   = ev[DEPTH-1];
  assign out_data    = data_p[DEPTH-1];
  assign stage_valid = vld_p;
  assign occupancy   = popcnt(vld_p);

  // Stage registers: data is loaded only from a live source.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_DATA;
    end else begin
      if (adv[0]) begin
        vld_p[0] <= in_valid;
        if (in_valid) data_p[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld_p[i] <= ev[i-1];
          if (ev[i-1]) data_p[i] <= data_p[i-1];
        end
      end
    end
  end

`ifdef PIPE_CHAIN_STATS_EN
  // Statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= sat_add32(stall_count, {31'd0, in_valid & ~in_ready});
      flush_count <= sat_add32(flush_count, 32'(popcnt(vld_p & flush)));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random traffic against an item-position model.
module tb_pipe_stage_chain;
  localparam int               DEPTH = 4;
  localparam int               WIDTH = 32;
  localparam logic [31:0]      RDATA = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [2:0]       occupancy;
`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0]      stall_count;
  logic [31:0]      flush_count;
`endif

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(RDATA)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stage_valid(stage_valid), .occupancy(occupancy)
`ifdef PIPE_CHAIN_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: items ordered oldest first, each with its stage index.
  logic [31:0] m_data [DEPTH];
  int          m_pos  [DEPTH];
  int          m_n;
  int          m_stall;
  int          m_flush;

  logic [31:0] outs[$];
  int          cyc;
  int          first_ov;
  int          max_occ;
  logic        obs_ir, obs_ov;
  logic [31:0] obs_od;
  logic [3:0]  obs_sv;
  int          obs_occ;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic [3:0] fl);
    logic [31:0] sd [DEPTH];
    int          sp [DEPTH];
    logic [31:0] td [DEPTH];
    int          tp [DEPTH];
    int          ns, nt, prev, nxt, killed;
    logic [3:0]  esv;
    logic        eov, eir;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    esv = '0; ns = 0; killed = 0;
    for (int k = 0; k < m_n; k++) begin
      esv[m_pos[k]] = 1'b1;
      if (fl[m_pos[k]]) killed++;
      else begin sd[ns] = m_data[k]; sp[ns] = m_pos[k]; ns++; end
    end
    eov  = (ns > 0) && (sp[0] == DEPTH-1);
    prev = DEPTH; nt = 0;
    for (int k = 0; k < ns; k++) begin
      if (sp[k] == DEPTH-1 && ordy) prev = DEPTH;
      else begin
        nxt = (sp[k] + 1 < prev) ? sp[k] + 1 : sp[k];
        td[nt] = sd[k]; tp[nt] = nxt; nt++;
        prev = nxt;
      end
    end
    eir = (nt == 0) || (tp[nt-1] > 0);

    chk("in_ready", in_ready, eir);
    chk("out_valid", out_valid, eov);
    if (eov) chk("out_data", out_data, sd[0]);
    chk("stage_valid", stage_valid, esv);
    chk("occupancy", occupancy, m_n);
`ifdef PIPE_CHAIN_STATS_EN
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
`endif
    obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data; obs_sv = stage_valid;
    obs_occ = int'(occupancy);
    if (obs_occ > max_occ) max_occ = obs_occ;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && ordy) outs.push_back(out_data);

    if (iv && !eir) m_stall++;
    m_flush += killed;
    for (int k = 0; k < nt; k++) begin m_data[k] = td[k]; m_pos[k] = tp[k]; end
    m_n = nt;
    if (iv && eir) begin m_data[m_n] = id; m_pos[m_n] = 0; m_n++; end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = $urandom; out_ready = 1'($urandom); flush = '0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = '0;
    #1;
    m_n = 0; m_stall = 0; m_flush = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stage_valid", stage_valid, 4'b0000);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, RDATA);
`ifdef PIPE_CHAIN_STATS_EN
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
`endif
    outs.delete(); cyc = 0; first_ov = -1; max_occ = 0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + 32'(i), 1'b0, 4'b0000);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0;
    m_n = 0; m_stall = 0; m_flush = 0;

    // Streaming latency and order
    do_reset();
    step(1'b1, 32'h11, 1'b1, 4'b0000);
    step(1'b1, 32'h22, 1'b1, 4'b0000);
    step(1'b1, 32'h33, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 4'b0000);
    chk("t1_first_ov_cycle", first_ov, 4);
    chk("t1_out_count", outs.size(), 3);
    chk("t1_out0", outs[0], 32'h11);
    chk("t1_out1", outs[1], 32'h22);
    chk("t1_out2", outs[2], 32'h33);
    chk("t1_max_occ", max_occ, 3);

    // Full chain stall then simultaneous in/out
    do_reset();
    fill(32'hA0);
    step(1'b1, 32'hA4, 1'b0, 4'b0000);
    chk("t2_full_in_ready", obs_ir, 1'b0);
    chk("t2_full_occ", obs_occ, 4);
    step(1'b1, 32'hA4, 1'b1, 4'b0000);
    chk("t2_pass_in_ready", obs_ir, 1'b1);
    chk("t2_pass_out", obs_od, 32'hA0);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    chk("t2_occ_after", obs_occ, 4);
    chk("t2_head_after", obs_od, 32'hA1);

    // Bubble collapse behind a stalled head
    do_reset();
    step(1'b1, 32'hD0, 1'b0, 4'b0000);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    step(1'b1, 32'hD1, 1'b0, 4'b0000);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    chk("t3_sv_before", obs_sv, 4'b1010);
    chk("t3_in_ready_before", obs_ir, 1'b1);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    chk("t3_sv_after", obs_sv, 4'b1100);
    chk("t3_in_ready_after", obs_ir, 1'b1);

    // Flush of the two youngest stages
    do_reset();
    fill(32'hB0);
    step(1'b0, 32'h0, 1'b1, 4'b0011);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 4'b0000);
    chk("t4_out_count", outs.size(), 2);
    chk("t4_out0", outs[0], 32'hB0);
    chk("t4_out1", outs[1], 32'hB1);

    // Reset while full
    do_reset();
    fill(32'hE0);
    do_reset();
    step(1'b1, 32'hC0, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 4'b0000);
    chk("t5_first_ov_cycle", first_ov, 4);
    chk("t5_out_count", outs.size(), 1);
    chk("t5_out0", outs[0], 32'hC0);

`ifdef PIPE_CHAIN_STATS_EN
    do_reset();
    fill(32'hF0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h55, 1'b0, 4'b0000);
    step(1'b0, 32'h0, 1'b0, 4'b1111);
    chk("t6_stall_count", stall_count, 10);
    step(1'b0, 32'h0, 1'b0, 4'b0000);
    chk("t6_flush_count", flush_count, 4);
    chk("t6_empty", obs_sv, 4'b0000);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline-register chain, the next generation of the hand-written per-stage pipeline registers in the processor top level. It carries a WIDTH-bit payload through DEPTH stages and adds per-stage valid bits, valid/ready back-pressure with bubble collapse, and per-stage flush. It is instantiated between datapath stages, for example IF->Dec or Dec->Exec, and once per field group.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_DATA, 0, reset value of every stage data register (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream item present
in_ready  output  1  chain accepts in_data this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage DEPTH-1 holds a live item
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  payload of stage DEPTH-1
flush  input  DEPTH  bit i kills the current content of stage i
stage_valid  output  DEPTH  registered valid bit per stage (bit 0 = input side)
occupancy  output  $clog2(DEPTH+1)  number of set stage_valid bits

Behaviour:
- Reset (rst=1 at posedge):
  - all v[i] <= 0 and all data[i] <= RESET_DATA.
  - Outputs after reset: out_valid=0, stage_valid=0, occupancy=0, in_ready=1, out_data=RESET_DATA.
  - rst overrides all other inputs; reset mid-operation drops every in-flight item silently.
- Effective valid: ev[i] = v[i] & ~flush[i] (combinational).
- Advance chain (combinational):
  - adv[DEPTH-1] = ~ev[DEPTH-1] | out_ready.
  - adv[i] = ~ev[i] | adv[i+1].
  - Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Handshakes:
  - in_ready = adv[0]; transfer in when in_valid & in_ready.
  - out_valid = ev[DEPTH-1] and out_data = data[DEPTH-1]; transfer out when out_valid & out_ready.
  - There is a combinational path out_ready -> in_ready through DEPTH levels; this is accepted by design.
- Stage update at posedge when adv[i]:
  - Stage 0: v[0] <= in_valid; data[0] <= in_data if in_valid.
  - Stage i>0: v[i] <= ev[i-1]; data[i] <= data[i-1] if ev[i-1].
  - data is not loaded from an invalid source; bench checks data only while valid.
- When ~adv[i]: stage i holds data and valid. A flushed stage always has adv=1, so it either reloads or becomes empty.
- Flush:
  - A flushed item never appears at out_data and never advances.
  - Multiple flush bits may be set at once; flush=all-ones empties the chain in one cycle while still accepting a new input.
  - flush[DEPTH-1] with out_ready=1: the item is not transferred, because out_valid=0.
- Latency: DEPTH cycles from input transfer to out_valid when unstalled. Throughput is 1 item/cycle. Ordering is strictly FIFO.
- Full: all ev=1 and out_ready=0 -> in_ready=0. With a full chain and out_ready=1, in_ready=1 (simultaneous in/out).
- Empty: out_valid=0; out_ready is ignored.
- occupancy = popcount(v), i.e. registered valid bits, not ev; range 0..DEPTH.

Optional Feature:
PIPE_CHAIN_STATS_EN
- Defined:
  - Adds output stall_count (32 bits), counting cycles with in_valid & ~in_ready.
  - Adds output flush_count (32 bits), counting items killed: popcount(v & flush) per cycle.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
1. DEPTH=4, WIDTH=32; after rst, stream 0x11,0x22,0x33 with out_ready=1 -> out_valid first at cycle 4 after the first accept; outputs 0x11,0x22,0x33 on consecutive cycles; occupancy peaks at 3.
2. Fill with 0xA0..0xA3 and hold out_ready=0 -> in_ready=0, occupancy=4. Raise out_ready for 1 cycle -> 0xA0 leaves, 0xA4 is accepted the same cycle, occupancy stays 4.
3. Bubble collapse: stages {v3=1, v2=0, v1=1, v0=0}, out_ready=0 -> after 1 cycle v1's item is in stage 2; in_ready=1 throughout.
4. Flush: chain holds 0xB0 (stage 3) .. 0xB3 (stage 0); assert flush=4'b0011 for one cycle with out_ready=1 -> output sequence is 0xB0, 0xB1 only; 0xB2 and 0xB3 never appear.
5. Reset mid-stream: chain full, assert rst for 1 cycle -> next cycle out_valid=0, stage_valid=0, out_data=RESET_DATA; subsequent input 0xC0 emerges after 4 cycles.
6. With PIPE_CHAIN_STATS_EN: hold a full chain stalled for 10 cycles with in_valid=1 -> stall_count=10; flush=4'b1111 on a full chain -> flush_count increments by 4.
